// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one physical-memory port between the I-cache and
// D-cache. One line per transaction, with a one-cycle DONE gap so the served cache can drop its request.
module cache_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_pmem_read,
    input  logic [ADDR_W-1:0] icache_pmem_address,
    output logic [LINE_W-1:0] icache_pmem_rdata,
    output logic              icache_pmem_resp,
    input  logic              dcache_pmem_read,
    input  logic              dcache_pmem_write,
    input  logic [ADDR_W-1:0] dcache_pmem_address,
    input  logic [LINE_W-1:0] dcache_pmem_wdata,
    output logic [LINE_W-1:0] dcache_pmem_rdata,
    output logic              dcache_pmem_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp,
    output logic              arb_busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2,
        DONE   = 2'd3
    } state_e;

    state_e            state_q;
    logic              last_grant_q;    // 1'b0 = I-cache, 1'b1 = D-cache
    logic              mem_read_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] mem_address_q;
    logic [LINE_W-1:0] mem_wdata_q;

    logic d_req_s;
    logic grant_i_s;
    logic grant_d_s;

    // On a tie the I-cache wins only if the D-cache had the previous grant.
    assign d_req_s   = dcache_pmem_read | dcache_pmem_write;
    assign grant_i_s = icache_pmem_read & (~d_req_s | last_grant_q);
    assign grant_d_s = d_req_s & ~grant_i_s;

    // Arbitration FSM; the memory request registers change only on grant and on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= {ADDR_W{1'b0}};
            mem_wdata_q   <= {LINE_W{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_i_s) begin
                        state_q       <= I_BUSY;
                        last_grant_q  <= 1'b0;
                        mem_read_q    <= 1'b1;
                        mem_write_q   <= 1'b0;
                        mem_address_q <= icache_pmem_address;
                    end else if (grant_d_s) begin
                        // A write-back beats a simultaneous fill from the same cache.
                        state_q       <= D_BUSY;
                        last_grant_q  <= 1'b1;
                        mem_read_q    <= ~dcache_pmem_write;
                        mem_write_q   <= dcache_pmem_write;
                        mem_address_q <= dcache_pmem_address;
                        if (dcache_pmem_write) begin
                            mem_wdata_q <= dcache_pmem_wdata;
                        end else begin
                            mem_wdata_q <= mem_wdata_q;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                I_BUSY, D_BUSY: begin
                    if (mem_resp) begin
                        state_q     <= DONE;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                    end else begin
                        state_q <= state_q;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q     <= IDLE;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                end
            endcase
        end
    end

    // Completion pulses are suppressed while reset abandons the in-flight transaction.
    assign icache_pmem_resp  = (state_q == I_BUSY) & mem_resp & ~rst;
    assign dcache_pmem_resp  = (state_q == D_BUSY) & mem_resp & ~rst;
    assign icache_pmem_rdata = mem_rdata;
    assign dcache_pmem_rdata = mem_rdata;

    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;
    assign arb_busy    = (state_q != IDLE);

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Shares the single physical-memory port between the instruction cache and the data cache of the pipelined RV32I core. Sits between the two caches' line-fill/write-back interfaces and the main memory, one cache line per transaction. Resolves simultaneous misses round-robin. Holds each granted transaction stable until memory responds, so the pipeline control only ever sees per-cache `resp` pulses.

## Interface
- LINE_W, 256, cache line width in bits
- ADDR_W, 32, line address width
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- icache_pmem_read  input  1  I-cache line-fill request (level, held until resp)
- icache_pmem_address  input  ADDR_W  I-cache line address
- icache_pmem_rdata  output  LINE_W  fill data to I-cache
- icache_pmem_resp  output  1  one-cycle completion pulse to I-cache
- dcache_pmem_read  input  1  D-cache line-fill request (level)
- dcache_pmem_write  input  1  D-cache write-back request (level)
- dcache_pmem_address  input  ADDR_W  D-cache line address
- dcache_pmem_wdata  input  LINE_W  write-back data
- dcache_pmem_rdata  output  LINE_W  fill data to D-cache
- dcache_pmem_resp  output  1  one-cycle completion pulse to D-cache
- mem_read  output  1  memory read request (registered)
- mem_write  output  1  memory write request (registered)
- mem_address  output  ADDR_W  latched transaction address (registered)
- mem_wdata  output  LINE_W  latched write data (registered)
- mem_rdata  input  LINE_W  memory read data, valid with mem_resp
- mem_resp  input  1  memory completion, one cycle
- arb_busy  output  1  high in any state other than IDLE

## Operation
- States: IDLE, I_BUSY, D_BUSY, DONE. Reset → IDLE.
- Registers: last_grant (1 bit, 0=I, 1=D), reset to D so the first tie goes to I.
- D request = dcache_pmem_read | dcache_pmem_write. If both D bits are high, the write wins.
- IDLE transitions:
  - Only I requesting → I_BUSY.
  - Only D requesting → D_BUSY.
  - Both requesting → grant the side opposite last_grant.
  - On grant: latch address, wdata (D write only) and op into the mem_* registers; set last_grant to the grantee.
  - No request → stay in IDLE.
- I_BUSY / D_BUSY:
  - Hold mem_read/mem_write/mem_address/mem_wdata constant; request inputs are ignored.
  - On mem_resp: pulse the owner's resp combinationally in the same cycle, clear mem_read/mem_write at the edge, go to DONE.
- DONE: one idle cycle with mem_read/mem_write low, so the served cache can drop its request before arbitration. Then → IDLE.
- mem_rdata is broadcast to both icache_pmem_rdata and dcache_pmem_rdata at all times. Only the resp signals are gated.
- icache_pmem_resp = (state==I_BUSY) & mem_resp. dcache_pmem_resp = (state==D_BUSY) & mem_resp. Both are never high together.
- A mem_resp seen in IDLE or DONE is ignored: no resp to either cache, no state change.

## Timing
- Reset values: mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, arb_busy=0, both resp=0, state=IDLE, last_grant=D.
- Request sampled in IDLE at cycle 0 → mem_read/mem_write high from cycle 1.
- mem_resp at cycle k → cache resp at cycle k → DONE at k+1 → IDLE at k+2. The earliest next memory request is at k+3.
- Minimum request-to-resp latency is 1 cycle (memory responding at cycle 1). The arbiter itself adds a 2-cycle turnaround per transaction.
- Requester dropping its request mid-BUSY: the transaction still completes, and the resp pulse is still issued.
- Requester changing address mid-BUSY: no effect on mem_address.
- rst asserted mid-transaction: next edge returns to IDLE with all outputs at reset values. The in-flight transaction is abandoned and no resp is issued.
- Under continuous contention, grants strictly alternate I, D, I, D.

## Test plan
- Single I fill, addr 0x0000_0040, memory resp after 5 cycles with rdata=pattern A → mem_read cycles 1–5, icache_pmem_resp only at cycle 5, rdata=A, dcache_pmem_resp never high, idle again at cycle 7.
- Single D write-back, addr 0x8000_0020, wdata=pattern B → mem_write=1, mem_address=0x8000_0020, mem_wdata=B held until resp, then dcache_pmem_resp pulse.
- I and D requesting together from reset, both held high across three transactions → grant order I, D, I. Each mem_read/mem_write starts 3 cycles after the prior mem_resp.
- D asserts read and write simultaneously → only mem_write is driven.
- Requester changes address 2 cycles after grant → mem_address unchanged.
- rst pulsed in cycle 3 of an I_BUSY transaction → cycle 4: mem_read=0, arb_busy=0; no icache_pmem_resp even if mem_resp arrives later.
- Stray mem_resp in IDLE → no resp on either cache port, state remains IDLE.
